// File: rtl/fft_stage_controller.sv
// -----------------------------------------------------------------------------
// fft_stage_controller
//
// Sequencing controller for a 32-point radix-2 FFT built from a 16-butterfly
// bank. One transform runs as: load 32 samples, run 5 butterfly stages
// (launch, wait for results, write back), unload 32 results, pulse done.
// All outputs decode from the registered state and counters; load_en
// additionally qualifies the LOAD state with in_valid.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request one transform (sampled only in IDLE)
//   in_valid     input sample present on the external sample bus
//   in_ready     controller accepts a sample this cycle (LOAD)
//   load_en      sample bank write enable (in_valid & in_ready)
//   load_idx     sample bank write index 0..31
//   twiddle_addr twiddle ROM stage select 0..4
//   stage_en     one-cycle launch pulse to the butterfly bank
//   bf_valid     butterfly bank results valid
//   wb_en        one-cycle write-back of butterfly results
//   out_valid    result at out_idx is available (UNLOAD)
//   out_ready    downstream consumes the result this cycle
//   out_idx      result register index 0..31
//   busy         high in every state except IDLE
//   done         one-cycle pulse at end of transform
// -----------------------------------------------------------------------------
module fft_stage_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic [4:0] load_idx,
  output logic [2:0] twiddle_addr,
  output logic       stage_en,
  input  logic       bf_valid,
  output logic       wb_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST_SAMPLE = 5'd31;
  localparam logic [2:0] LAST_STAGE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4,
    S_UNLOAD = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [4:0] sample_cnt, sample_nx;
  logic [2:0] stage_cnt, stage_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      stage_cnt  <= '0;
    end else begin
      state      <= state_nx;
      sample_cnt <= sample_nx;
      stage_cnt  <= stage_nx;
    end
  end

  // Terminal counter values force the state exit, so neither counter wraps.
  // The sample counter is returned to 0 on leaving LOAD and UNLOAD, which
  // keeps both index outputs at 0 in every other state.
  always_comb begin
    state_nx  = state;
    sample_nx = sample_cnt;
    stage_nx  = stage_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx  = S_LOAD;
          sample_nx = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (sample_cnt == LAST_SAMPLE) begin
            state_nx  = S_ISSUE;
            sample_nx = '0;
            stage_nx  = '0;
          end else begin
            sample_nx = sample_cnt + 5'd1;
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (bf_valid) state_nx = S_WB;
      end
      S_WB: begin
        if (stage_cnt == LAST_STAGE) begin
          state_nx = S_UNLOAD;
          stage_nx = '0;
        end else begin
          state_nx = S_ISSUE;
          stage_nx = stage_cnt + 3'd1;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (sample_cnt == LAST_SAMPLE) begin
            state_nx  = S_DONE;
            sample_nx = '0;
          end else begin
            sample_nx = sample_cnt + 5'd1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: begin
        state_nx  = S_IDLE;
        sample_nx = '0;
        stage_nx  = '0;
      end
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    load_en      = 1'b0;
    load_idx     = '0;
    twiddle_addr = '0;
    stage_en     = 1'b0;
    wb_en        = 1'b0;
    out_valid    = 1'b0;
    out_idx      = '0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        load_en  = in_valid;
        load_idx = sample_cnt;
      end
      S_ISSUE: begin
        stage_en     = 1'b1;
        twiddle_addr = stage_cnt;
      end
      S_WAIT: twiddle_addr = stage_cnt;
      S_WB: begin
        wb_en        = 1'b1;
        twiddle_addr = stage_cnt;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_idx   = sample_cnt;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_stage_controller.sv
module tb_fft_stage_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       load_en;
  logic [4:0] load_idx;
  logic [2:0] twiddle_addr;
  logic       stage_en;
  logic       bf_valid = 1'b0;
  logic       wb_en;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_idx;
  logic       busy;
  logic       done;

  fft_stage_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .load_en(load_en), .load_idx(load_idx),
    .twiddle_addr(twiddle_addr), .stage_en(stage_en), .bf_valid(bf_valid),
    .wb_en(wb_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus controls
  int cyc = 0;
  int run_cyc = 0;
  bit rst_req = 1'b1;
  bit start_pulse = 1'b0;
  bit start_hold = 1'b0;
  bit spur = 1'b0;
  int in_pat = 0;
  int out_pat = 0;
  int bf_delay = 2;
  int bf_cnt = -1;

  // per-run observations
  int n_load, n_stage, n_wb, n_out, n_done, done_cyc, exp_load, exp_out, stage_cyc;
  bit load_ok, out_ok, wb_ok, tw_ok;
  int tw_seq[$];

  task automatic clear_rec();
    n_load = 0; n_stage = 0; n_wb = 0; n_out = 0; n_done = 0; done_cyc = -1;
    exp_load = 0; exp_out = 0; stage_cyc = -100;
    load_ok = 1'b1; out_ok = 1'b1; wb_ok = 1'b1; tw_ok = 1'b1;
    tw_seq.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, observe 1 ns later.
  task automatic step();
    logic se, ir, wait_now;
    int gap;
    @(negedge clk);
    cyc++;
    run_cyc++;
    se = stage_en;
    ir = in_ready;
    wait_now = busy && !in_ready && !stage_en && !wb_en && !out_valid && !done;
    rst_n = !rst_req;
    start = start_hold || (start_pulse && run_cyc == 1) || (spur && wait_now);
    in_valid  = (in_pat == 0)  ? 1'b1 : ((cyc % 2) == 1);
    out_ready = (out_pat == 0) ? 1'b1 : ((cyc % 2) == 0);
    if (rst_req) begin
      bf_cnt = -1; bf_valid = 1'b0;
    end else if (bf_delay == 0) begin
      bf_valid = 1'b1;
    end else if (se === 1'b1) begin
      bf_cnt = 0; bf_valid = 1'b0;
    end else if (bf_cnt >= 0) begin
      bf_cnt++;
      bf_valid = (bf_cnt == bf_delay);
      if (bf_valid) bf_cnt = -1;
    end else begin
      bf_valid = 1'b0;
    end
    if (spur && (ir === 1'b1 || se === 1'b1)) bf_valid = 1'b1;
    #1;
    if (in_ready === 1'b1) begin
      if (load_idx !== exp_load[4:0]) load_ok = 1'b0;
      if (load_en !== in_valid) load_ok = 1'b0;
      if (load_en === 1'b1) begin n_load++; exp_load++; end
    end else if (load_en === 1'b1) load_ok = 1'b0;
    if (out_valid === 1'b1) begin
      if (out_idx !== exp_out[4:0]) out_ok = 1'b0;
      if (out_ready) begin n_out++; exp_out++; end
    end
    if (stage_en === 1'b1) begin
      tw_seq.push_back(int'(twiddle_addr)); n_stage++; stage_cyc = cyc;
    end
    if (wb_en === 1'b1) begin
      gap = (bf_delay == 0) ? 2 : bf_delay + 1;
      n_wb++;
      if (cyc - stage_cyc != gap) wb_ok = 1'b0;
    end
    if (twiddle_addr > 3'd4) tw_ok = 1'b0;
    if (done === 1'b1) begin n_done++; done_cyc = run_cyc; end
  endtask

  task automatic do_reset();
    rst_req = 1'b1; start_pulse = 1'b0; start_hold = 1'b0;
    step(); step();
    rst_req = 1'b0;
  endtask

  // Launch one transform and step until done or the cycle budget expires.
  task automatic run_transform();
    clear_rec();
    run_cyc = 0;
    start_pulse = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (n_done > 0) break;
    end
    start_pulse = 1'b0;
    checks++;
    if (n_done == 0) begin
      failures++; $display("FAIL run_timeout: got no done within 3000 cycles, expected done");
    end
  endtask

  task automatic test_reset();
    in_pat = 0; out_pat = 0; spur = 1'b0; bf_delay = 2;
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (load_en !== 1'b0) begin failures++; $display("FAIL reset_load_en: got %b expected 0", load_en); end
    checks++; if (stage_en !== 1'b0 || wb_en !== 1'b0) begin failures++; $display("FAIL reset_stage_wb: got %b%b expected 00", stage_en, wb_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (load_idx !== 5'd0 || out_idx !== 5'd0) begin failures++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", load_idx, out_idx); end
    checks++; if (twiddle_addr !== 3'd0) begin failures++; $display("FAIL reset_twiddle: got %0d expected 0", twiddle_addr); end
  endtask

  task automatic test_nominal();
    in_pat = 0; out_pat = 0; spur = 1'b0; bf_delay = 2;
    do_reset();
    run_transform();
    checks++; if (n_stage != 5) begin failures++; $display("FAIL nom_stage_en_count: got %0d expected 5", n_stage); end
    checks++; if (n_wb != 5) begin failures++; $display("FAIL nom_wb_en_count: got %0d expected 5", n_wb); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((i < tw_seq.size() ? tw_seq[i] : -1) != i) begin
        failures++; $display("FAIL nom_twiddle_%0d: got %0d expected %0d", i, (i < tw_seq.size() ? tw_seq[i] : -1), i);
      end
    end
    checks++; if (!wb_ok) begin failures++; $display("FAIL nom_wb_timing: got mistimed wb_en expected 3 cycles after stage_en"); end
    checks++; if (n_load != 32 || !load_ok) begin failures++; $display("FAIL nom_load: got %0d loads ok=%0d expected 32 ok=1", n_load, load_ok); end
    checks++; if (n_out != 32 || !out_ok) begin failures++; $display("FAIL nom_unload: got %0d outputs ok=%0d expected 32 ok=1", n_out, out_ok); end
    checks++; if (!tw_ok) begin failures++; $display("FAIL nom_twiddle_range: got value above 4 expected <=4"); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL nom_after_done: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL nom_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_throttled();
    in_pat = 1; out_pat = 1; spur = 1'b0; bf_delay = 2;
    do_reset();
    run_transform();
    checks++; if (n_load != 32) begin failures++; $display("FAIL thr_load_count: got %0d expected 32", n_load); end
    checks++; if (!load_ok) begin failures++; $display("FAIL thr_load_idx: got index advancing on idle cycle expected accepted only"); end
    checks++; if (n_out != 32) begin failures++; $display("FAIL thr_out_count: got %0d expected 32", n_out); end
    checks++; if (!out_ok) begin failures++; $display("FAIL thr_out_idx: got out of order expected 0..31"); end
    checks++; if (n_stage != 5 || n_wb != 5) begin failures++; $display("FAIL thr_stages: got %0d/%0d expected 5/5", n_stage, n_wb); end
    in_pat = 0; out_pat = 0;
  endtask

  task automatic test_spurious();
    in_pat = 0; out_pat = 0; spur = 1'b1; bf_delay = 3;
    do_reset();
    run_transform();
    checks++; if (!wb_ok) begin failures++; $display("FAIL spur_early_wb: got wb_en at wrong cycle expected 4 cycles after stage_en"); end
    checks++; if (n_stage != 5 || n_wb != 5) begin failures++; $display("FAIL spur_stages: got %0d/%0d expected 5/5", n_stage, n_wb); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((i < tw_seq.size() ? tw_seq[i] : -1) != i) begin
        failures++; $display("FAIL spur_twiddle_%0d: got %0d expected %0d", i, (i < tw_seq.size() ? tw_seq[i] : -1), i);
      end
    end
    checks++; if (n_load != 32 || !load_ok || n_out != 32 || !out_ok) begin failures++; $display("FAIL spur_restart: got loads=%0d outs=%0d expected 32 32 in order", n_load, n_out); end
    spur = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    in_pat = 0; out_pat = 0; spur = 1'b0; bf_delay = 3;
    do_reset();
    clear_rec();
    run_cyc = 0;
    start_pulse = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (stage_en === 1'b1 && twiddle_addr === 3'd2) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_reach_stage2: got no stage 2 launch expected one"); end
    rst_req = 1'b1;
    step();
    checks++; if (twiddle_addr !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL rmid_in_wait: got twiddle=%0d busy=%b expected 2 1", twiddle_addr, busy); end
    rst_req = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || load_en !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_outputs: got busy=%b in_ready=%b load_en=%b out_valid=%b expected 0000", busy, in_ready, load_en, out_valid);
    end
    checks++; if (stage_en !== 1'b0 || wb_en !== 1'b0 || twiddle_addr !== 3'd0) begin failures++; $display("FAIL rmid_stage_out: got se=%b wb=%b tw=%0d expected 0 0 0", stage_en, wb_en, twiddle_addr); end
    for (int k = 0; k < 6; k++) step();
    checks++; if (n_done != 0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_abandon: got done=%0d busy=%b expected 0 0", n_done, busy); end
    bf_delay = 2;
    run_transform();
    checks++; if (n_stage != 5 || tw_seq.size() != 5) begin failures++; $display("FAIL rmid_restart_stages: got %0d expected 5", n_stage); end
    else begin
      checks++; if (tw_seq[0] != 0 || tw_seq[4] != 4) begin failures++; $display("FAIL rmid_restart_seq: got %0d..%0d expected 0..4", tw_seq[0], tw_seq[4]); end
    end
    checks++; if (n_load != 32 || !load_ok) begin failures++; $display("FAIL rmid_restart_load: got %0d ok=%0d expected 32 ok=1", n_load, load_ok); end
  endtask

  task automatic test_back_to_back();
    in_pat = 0; out_pat = 0; spur = 1'b0; bf_delay = 0;
    do_reset();
    start_hold = 1'b1;
    run_transform();
    checks++; if (done_cyc != 81) begin failures++; $display("FAIL b2b_latency: got done in cycle %0d expected 81", done_cyc); end
    step();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got busy=%b in_ready=%b expected 0 0", busy, in_ready); end
    step();
    checks++; if (in_ready !== 1'b1 || load_idx !== 5'd0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_second_load: got in_ready=%b idx=%0d busy=%b expected 1 0 1", in_ready, load_idx, busy); end
    start_hold = 1'b0;
    bf_delay = 2;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_throttled();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
